// File: rtl/normalizer_if.sv
// Operand/result bundle for the normalizer: the start request with its operand,
// and the result, status and completion strobe returned by the block.
interface normalizer_if;
    logic        start;
    logic [31:0] A;
    logic        ctl0;
    logic [31:0] out;
    logic [4:0]  count;
    logic        zero;
    logic        busy;
    logic        done;

    modport master (
        output start, A, ctl0,
        input  out, count, zero, busy, done
    );

    modport slave (
        input  start, A, ctl0,
        output out, count, zero, busy, done
    );
endinterface

// File: rtl/normalizer.sv
// Multi-cycle left normalizer: a 5-step binary search (16,8,4,2,1) for leading zeros
// (ctl0=1) or redundant sign bits (ctl0=0). NORMALIZER_EARLY_DONE_EN skips the search
// for operands that are already normalized.
module normalizer (
    input  logic       clk,
    input  logic       reset,
    normalizer_if.slave bus
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e      state_q, state_d;
    logic [31:0] work_q, work_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        mode_q, mode_d;
    logic [2:0]  step_q, step_d;
    logic        zflag_q, zflag_d;
    logic [31:0] out_q, out_d;
    logic [4:0]  count_q, count_d;
    logic        zero_q, zero_d;

    logic        accept;
    logic        early;
    logic        last_step;
    logic        take;
    logic [5:0]  w;
    logic [31:0] mask_l, mask_a, top_a;
    logic [31:0] work_step;
    logic [4:0]  cnt_step;

    assign accept    = bus.start && (state_q != StRun);
    assign last_step = (step_q == 3'd4);

`ifdef NORMALIZER_EARLY_DONE_EN
    assign early = bus.ctl0 ? bus.A[31] : (bus.A[31] ^ bus.A[30]);
`else
    assign early = 1'b0;
`endif

    // Arithmetic mode needs w+1 equal top bits so the sign survives the shift.
    assign w      = 6'd16 >> step_q;
    assign mask_l = ~(32'hFFFF_FFFF >> w);
    assign mask_a = ~(32'hFFFF_FFFF >> (w + 6'd1));
    assign top_a  = work_q & mask_a;
    assign take   = mode_q ? ((work_q & mask_l) == 32'd0)
                           : ((top_a == 32'd0) || (top_a == mask_a));

    assign work_step = take ? (work_q << w) : work_q;
    assign cnt_step  = take ? (cnt_q + w[4:0]) : cnt_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle,
            StDone:  state_d = accept ? (early ? StDone : StRun) : StIdle;
            StRun:   if (last_step) state_d = StDone;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy  = (state_q == StRun);
        bus.done  = (state_q == StDone);
        bus.out   = out_q;
        bus.count = count_q;
        bus.zero  = zero_q;
    end

    always_comb begin
        work_d  = work_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        step_d  = step_q;
        zflag_d = zflag_q;
        out_d   = out_q;
        count_d = count_q;
        zero_d  = zero_q;
        if (accept) begin
            work_d  = bus.A;
            cnt_d   = 5'd0;
            mode_d  = bus.ctl0;
            step_d  = 3'd0;
            zflag_d = (bus.A == 32'd0) || (!bus.ctl0 && (bus.A == 32'hFFFF_FFFF));
            if (early) begin
                out_d   = bus.A;
                count_d = 5'd0;
                zero_d  = 1'b0;
            end
        end else if (state_q == StRun) begin
            work_d = work_step;
            cnt_d  = cnt_step;
            step_d = step_q + 3'd1;
            // Results only become visible on entry to DONE and then hold.
            if (last_step) begin
                out_d   = work_step;
                count_d = cnt_step;
                zero_d  = zflag_q;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q  <= 32'd0;
            cnt_q   <= 5'd0;
            mode_q  <= 1'b0;
            step_q  <= 3'd0;
            zflag_q <= 1'b0;
            out_q   <= 32'd0;
            count_q <= 5'd0;
            zero_q  <= 1'b0;
        end else begin
            work_q  <= work_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
            step_q  <= step_d;
            zflag_q <= zflag_d;
            out_q   <= out_d;
            count_q <= count_d;
            zero_q  <= zero_d;
        end
    end

endmodule

// File: tb/tb_normalizer.sv
// Directed-vector bench for the normalizer with hand-computed expected results.
module tb_normalizer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    normalizer_if bus ();

    normalizer u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

`ifdef NORMALIZER_EARLY_DONE_EN
    localparam int EarlyLat = 1;
`else
    localparam int EarlyLat = 6;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for done; edges counts clock edges with the start edge as edge 1.
    task automatic wait_done(inout int edges, output int busy_cyc);
        busy_cyc = 0;
        while (!bus.done && edges < 20) begin
            if (bus.busy) busy_cyc++;
            step();
            edges++;
        end
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic mode,
                          input logic [4:0] e_cnt, input logic [31:0] e_out,
                          input logic e_zero, input int e_lat, input bit hold);
        int edges;
        int busy_cyc;
        bus.start = 1'b1;
        bus.A     = a;
        bus.ctl0  = mode;
        step();
        edges     = 1;
        bus.start = 1'b0;
        bus.A     = ~a;
        bus.ctl0  = ~mode;
        wait_done(edges, busy_cyc);
        check_eq({tag, "/latency"}, edges, e_lat);
        check_eq({tag, "/busy_cycles"}, busy_cyc, (e_lat == 1) ? 0 : 5);
        check_eq({tag, "/count"}, bus.count, e_cnt);
        check_eq({tag, "/out"}, bus.out, e_out);
        check_eq({tag, "/zero"}, bus.zero, e_zero);
        if (hold) begin
            step();
            check_eq({tag, "/done_pulse"}, bus.done, 1'b0);
            check_eq({tag, "/hold_out"}, bus.out, e_out);
            check_eq({tag, "/hold_count"}, bus.count, e_cnt);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int edges;
        int busy_cyc;
        int n_done;

        reset     = 1'b1;
        bus.start = 1'b0;
        bus.A     = 32'd0;
        bus.ctl0  = 1'b0;
        step();
        step();
        check_eq("rst/out", bus.out, 32'd0);
        check_eq("rst/count", bus.count, 5'd0);
        check_eq("rst/zero", bus.zero, 1'b0);
        check_eq("rst/busy", bus.busy, 1'b0);
        check_eq("rst/done", bus.done, 1'b0);
        reset = 1'b0;

        run_op("clz_10000", 32'h0001_0000, 1'b1, 5'd15, 32'h8000_0000, 1'b0, 6, 1'b1);
        run_op("clz_zero",  32'h0000_0000, 1'b1, 5'd31, 32'h0000_0000, 1'b1, 6, 1'b1);
        run_op("clz_one",   32'h0000_0001, 1'b1, 5'd31, 32'h8000_0000, 1'b0, 6, 1'b1);
        run_op("cls_ffff0", 32'hFFFF_0000, 1'b0, 5'd15, 32'h8000_0000, 1'b0, 6, 1'b1);
        run_op("cls_ones",  32'hFFFF_FFFF, 1'b0, 5'd31, 32'h8000_0000, 1'b1, 6, 1'b1);
        run_op("cls_zero",  32'h0000_0000, 1'b0, 5'd31, 32'h0000_0000, 1'b1, 6, 1'b1);
        run_op("clz_norm",  32'h8000_0000, 1'b1, 5'd0,  32'h8000_0000, 1'b0, EarlyLat, 1'b1);
        run_op("cls_norm",  32'h4000_0000, 1'b0, 5'd0,  32'h4000_0000, 1'b0, EarlyLat, 1'b1);

        // Start while busy is ignored; then a restart in the DONE cycle runs back-to-back.
        bus.start = 1'b1;
        bus.A     = 32'h0000_0100;
        bus.ctl0  = 1'b1;
        step();
        edges     = 1;
        bus.start = 1'b0;
        step();
        edges++;
        bus.start = 1'b1;
        bus.A     = 32'h0000_0001;
        step();
        edges++;
        bus.start = 1'b0;
        wait_done(edges, busy_cyc);
        check_eq("ignore/latency", edges, 6);
        check_eq("ignore/count", bus.count, 5'd23);
        check_eq("ignore/out", bus.out, 32'h8000_0000);
        check_eq("ignore/zero", bus.zero, 1'b0);
        run_op("b2b", 32'h0001_0000, 1'b1, 5'd15, 32'h8000_0000, 1'b0, 6, 1'b0);

        // Reset during the third RUN cycle, with a competing start on the same edge.
        bus.start = 1'b1;
        bus.A     = 32'h0000_0001;
        bus.ctl0  = 1'b1;
        step();
        bus.start = 1'b0;
        step();
        step();
        check_eq("abort/busy_before", bus.busy, 1'b1);
        reset     = 1'b1;
        bus.start = 1'b1;
        step();
        reset     = 1'b0;
        bus.start = 1'b0;
        check_eq("abort/out", bus.out, 32'd0);
        check_eq("abort/count", bus.count, 5'd0);
        check_eq("abort/zero", bus.zero, 1'b0);
        check_eq("abort/busy", bus.busy, 1'b0);
        check_eq("abort/done", bus.done, 1'b0);
        n_done = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (bus.done || bus.busy) n_done++;
        end
        check_eq("abort/no_activity", n_done, 0);

        run_op("post_rst", 32'h0000_0100, 1'b1, 5'd23, 32'h8000_0000, 1'b0, 6, 1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
